// File: rtl/miller_rx_frame_ctrl_pkg.sv
// Shared types and constants for the ISO 14443-A reader->card receive sequencer.
// Parity checking is built in only when MILLER_RX_PARITY_EN is defined.
package miller_rx_frame_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SOF_WAIT,
        ST_RECEIVE,
        ST_CLOSE
    } rx_state_t;

    localparam int ISO14443A_SHORT_FRAME_BITS = 7;
    localparam int BITS_PER_CHAR              = 9;
    localparam int DEFAULT_ETU_CLKS           = 32;
    localparam int DEFAULT_TIMEOUT_ETU        = 4;
    localparam int DEFAULT_MAX_BYTES          = 64;

endpackage

// File: rtl/miller_rx_frame_ctrl_if.sv
// Bundle between the Miller receive chain / protocol layer and the frame sequencer.
// slave = sequencer side, master = chain/protocol side.
interface miller_rx_frame_ctrl_if #(
    parameter int MAX_BYTES = 64
);
    localparam int CNT_W = $clog2(MAX_BYTES + 1);

    logic             in_enable;
    logic             in_sof_detected;
    logic             in_bit_valid;
    logic             in_bit;
    logic             in_eof;
    logic             out_dec_enable;
    logic             out_chain_clear;
    logic [7:0]       out_byte;
    logic             out_byte_valid;
    logic [CNT_W-1:0] out_byte_cnt;
    logic             out_frame_done;
    logic             out_short_frame;
    logic             out_parity_err;
    logic             out_frame_err;

    modport slave (
        input  in_enable,
        input  in_sof_detected,
        input  in_bit_valid,
        input  in_bit,
        input  in_eof,
        output out_dec_enable,
        output out_chain_clear,
        output out_byte,
        output out_byte_valid,
        output out_byte_cnt,
        output out_frame_done,
        output out_short_frame,
        output out_parity_err,
        output out_frame_err
    );

    modport master (
        output in_enable,
        output in_sof_detected,
        output in_bit_valid,
        output in_bit,
        output in_eof,
        input  out_dec_enable,
        input  out_chain_clear,
        input  out_byte,
        input  out_byte_valid,
        input  out_byte_cnt,
        input  out_frame_done,
        input  out_short_frame,
        input  out_parity_err,
        input  out_frame_err
    );

endinterface

// File: rtl/miller_rx_frame_ctrl_byte_assembler.sv
// LSB-first character assembler: 8 data bits then one parity bit per character.
// MILLER_RX_PARITY_EN selects odd-parity checking; otherwise the 9th bit is dropped.
module miller_rx_byte_assembler
    import miller_rx_frame_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       clear,
    input  logic       bit_valid,
    input  logic       bit_in,
    input  logic       emit_ok,
    output logic [3:0] idx_next,
    output logic       char_done,
    output logic [7:0] data,
    output logic [7:0] byte_q,
    output logic       byte_strobe,
    output logic       parity_bad
);

    localparam logic [3:0] PAR_IDX = 4'(BITS_PER_CHAR - 1);

    logic [3:0] bit_idx;

    always_comb begin
        char_done = bit_valid && (bit_idx == PAR_IDX);
        idx_next  = bit_idx;
        if (clear) begin
            idx_next = 4'd0;
        end else if (bit_valid) begin
            idx_next = char_done ? 4'd0 : bit_idx + 4'd1;
        end
    end

`ifdef MILLER_RX_PARITY_EN
    // Odd parity: the parity bit makes the total count of ones odd.
    always_comb begin
        parity_bad = char_done && (bit_in != ~^data);
    end
`else
    always_comb begin
        parity_bad = 1'b0;
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            bit_idx     <= 4'd0;
            data        <= 8'd0;
            byte_q      <= 8'd0;
            byte_strobe <= 1'b0;
        end else begin
            bit_idx     <= idx_next;
            byte_strobe <= char_done && emit_ok;
            if (bit_valid && !char_done) begin
                data[bit_idx[2:0]] <= bit_in;
            end
            if (char_done && emit_ok) begin
                byte_q <= data;
            end
        end
    end

endmodule

// File: rtl/miller_rx_frame_ctrl.sv
// Receive-frame sequencer: arms the Miller chain, frames bytes, closes on EoF/timeout.
// Define MILLER_RX_PARITY_EN to enable odd-parity checking of each character.
module miller_rx_frame_ctrl
    import miller_rx_frame_ctrl_pkg::*;
#(
    parameter int ETU_CLKS    = DEFAULT_ETU_CLKS,
    parameter int TIMEOUT_ETU = DEFAULT_TIMEOUT_ETU,
    parameter int MAX_BYTES   = DEFAULT_MAX_BYTES
) (
    input logic                   in_clk,
    input logic                   in_rst,
    miller_rx_frame_ctrl_if.slave bus
);

    localparam int CNT_W    = $clog2(MAX_BYTES + 1);
    localparam int WD_LIMIT = TIMEOUT_ETU * ETU_CLKS;
    localparam int WD_W     = $clog2(WD_LIMIT + 1);

    localparam logic [WD_W-1:0]  WD_MAX    = WD_W'(WD_LIMIT);
    localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(MAX_BYTES);
    localparam logic [3:0]       SHORT_IDX = 4'(ISO14443A_SHORT_FRAME_BITS);

    rx_state_t        state;
    rx_state_t        state_nxt;
    logic [WD_W-1:0]  wd_cnt;
    logic [CNT_W-1:0] byte_cnt;
    logic             short_q;
    logic             perr_q;
    logic             ferr_q;

    logic             in_rx;
    logic             sof_accept;
    logic             bit_rx;
    logic             eof_rx;
    logic             emit_ok;
    logic             overflow;
    logic             timeout;
    logic             short_cond;
    logic             short_set;
    logic             ferr_set;
    logic             close_now;

    logic [3:0]       idx_next;
    logic             char_done;
    logic [7:0]       asm_data;
    logic [7:0]       asm_byte;
    logic             asm_strobe;
    logic             parity_bad;

    miller_rx_byte_assembler u_asm (
        .clk         (in_clk),
        .rst         (in_rst),
        .clear       (sof_accept),
        .bit_valid   (bit_rx),
        .bit_in      (bus.in_bit),
        .emit_ok     (emit_ok),
        .idx_next    (idx_next),
        .char_done   (char_done),
        .data        (asm_data),
        .byte_q      (asm_byte),
        .byte_strobe (asm_strobe),
        .parity_bad  (parity_bad)
    );

    // EoF is classified on the index after any same-cycle bit.
    always_comb begin
        in_rx      = (state == ST_RECEIVE);
        sof_accept = (state == ST_SOF_WAIT) && bus.in_enable && bus.in_sof_detected;
        bit_rx     = in_rx && bus.in_bit_valid;
        eof_rx     = in_rx && bus.in_eof;
        emit_ok    = (byte_cnt != CNT_MAX);
        overflow   = char_done && !emit_ok;
        timeout    = in_rx && !bit_rx && (wd_cnt == WD_MAX);
        short_cond = (byte_cnt == '0) && (idx_next == SHORT_IDX);
        short_set  = eof_rx && !overflow && short_cond;
        ferr_set   = overflow
                   || (eof_rx && !short_cond && (idx_next != 4'd0))
                   || (!eof_rx && timeout);
        close_now  = in_rx && (overflow || eof_rx || timeout);
    end

    always_comb begin
        state_nxt           = state;
        bus.out_dec_enable  = 1'b0;
        bus.out_chain_clear = 1'b0;
        bus.out_frame_done  = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (bus.in_enable) state_nxt = ST_SOF_WAIT;
            end
            ST_SOF_WAIT: begin
                if (!bus.in_enable) begin
                    state_nxt           = ST_IDLE;
                    bus.out_chain_clear = 1'b1;
                end else if (bus.in_sof_detected) begin
                    state_nxt = ST_RECEIVE;
                end
            end
            ST_RECEIVE: begin
                bus.out_dec_enable = 1'b1;
                if (close_now) state_nxt = ST_CLOSE;
            end
            ST_CLOSE: begin
                bus.out_frame_done  = 1'b1;
                bus.out_chain_clear = 1'b1;
                state_nxt = bus.in_enable ? ST_SOF_WAIT : ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge in_clk) begin
        if (in_rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Watchdog saturates at its limit rather than wrapping.
    always_ff @(posedge in_clk) begin
        if (in_rst || !in_rx || bit_rx) begin
            wd_cnt <= '0;
        end else if (wd_cnt != WD_MAX) begin
            wd_cnt <= wd_cnt + 1'b1;
        end
    end

    always_ff @(posedge in_clk) begin
        if (in_rst || sof_accept) begin
            byte_cnt <= '0;
            short_q  <= 1'b0;
            perr_q   <= 1'b0;
            ferr_q   <= 1'b0;
        end else begin
            if (char_done && emit_ok) byte_cnt <= byte_cnt + 1'b1;
            if (parity_bad) perr_q <= 1'b1;
            if (short_set) short_q <= 1'b1;
            if (close_now && ferr_set) ferr_q <= 1'b1;
        end
    end

    assign bus.out_byte        = short_q
                               ? 8'(asm_data[ISO14443A_SHORT_FRAME_BITS-1:0])
                               : asm_byte;
    assign bus.out_byte_valid  = asm_strobe || ((state == ST_CLOSE) && short_q);
    assign bus.out_byte_cnt    = byte_cnt;
    assign bus.out_short_frame = short_q;
    assign bus.out_parity_err  = perr_q;
    assign bus.out_frame_err   = ferr_q;

endmodule

// File: tb/tb_miller_rx_frame_ctrl.sv
// Scoreboard bench for miller_rx_frame_ctrl: expected bytes and frame
// status are queued at stimulus time and compared when the DUT strobes.
module tb_miller_rx_frame_ctrl;
    import miller_rx_frame_ctrl_pkg::*;

    localparam int MAXB = 64;

`ifdef MILLER_RX_PARITY_EN
    localparam bit PAR_ON = 1'b1;
`else
    localparam bit PAR_ON = 1'b0;
`endif

    typedef struct {
        int cnt;
        bit sh;
        bit pe;
        bit fe;
    } frame_t;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    miller_rx_frame_ctrl_if #(.MAX_BYTES(MAXB)) bus ();

    miller_rx_frame_ctrl #(
        .ETU_CLKS    (32),
        .TIMEOUT_ETU (4),
        .MAX_BYTES   (MAXB)
    ) dut (
        .in_clk (clk),
        .in_rst (rst),
        .bus    (bus.slave)
    );

    logic [7:0] exp_bytes[$];
    frame_t     exp_frames[$];
    int         checks = 0;
    int         errors = 0;
    int         n_done = 0;
    logic [7:0] mon_b;
    frame_t     mon_f;

    // Scoreboard side: pop and compare on every DUT strobe.
    always @(negedge clk) begin
        if (rst === 1'b0) begin
            if (bus.out_byte_valid === 1'b1) begin
                checks++;
                if (exp_bytes.size() == 0) begin
                    errors++;
                    $display("FAIL byte_unexpected got=%02h", bus.out_byte);
                end else begin
                    mon_b = exp_bytes.pop_front();
                    if (bus.out_byte !== mon_b) begin
                        errors++;
                        $display("FAIL byte got=%02h exp=%02h", bus.out_byte, mon_b);
                    end
                end
            end
            if (bus.out_frame_done === 1'b1) begin
                n_done++;
                checks++;
                if (exp_frames.size() == 0) begin
                    errors++;
                    $display("FAIL frame_unexpected cnt=%0d", bus.out_byte_cnt);
                end else begin
                    mon_f = exp_frames.pop_front();
                    if (int'(bus.out_byte_cnt) !== mon_f.cnt
                        || bus.out_short_frame !== mon_f.sh
                        || bus.out_parity_err !== mon_f.pe
                        || bus.out_frame_err !== mon_f.fe) begin
                        errors++;
                        $display("FAIL frame got cnt=%0d sh=%b pe=%b fe=%b exp cnt=%0d sh=%b pe=%b fe=%b",
                                 bus.out_byte_cnt, bus.out_short_frame,
                                 bus.out_parity_err, bus.out_frame_err,
                                 mon_f.cnt, mon_f.sh, mon_f.pe, mon_f.fe);
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        bus.in_bit_valid = 1'b1;
        bus.in_bit       = b;
        tick();
        bus.in_bit_valid = 1'b0;
        bus.in_bit       = 1'b0;
        tick();
    endtask

    task automatic send_char(input logic [7:0] d, input bit flip, input bit push);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        if (push) exp_bytes.push_back(d);
        send_bit((~^d) ^ flip);
    endtask

    task automatic start_frame();
        bus.in_enable = 1'b1;
        tick();
        bus.in_sof_detected = 1'b1;
        tick();
        bus.in_sof_detected = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.out_dec_enable !== 1'b1 || bus.out_byte_cnt !== '0
            || bus.out_short_frame !== 1'b0 || bus.out_parity_err !== 1'b0
            || bus.out_frame_err !== 1'b0) begin
            errors++;
            $display("FAIL sof_entry got dec=%b cnt=%0d sh=%b pe=%b fe=%b exp 1 0 0 0 0",
                     bus.out_dec_enable, bus.out_byte_cnt, bus.out_short_frame,
                     bus.out_parity_err, bus.out_frame_err);
        end
    endtask

    task automatic send_eof();
        bus.in_eof = 1'b1;
        tick();
        bus.in_eof = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.out_frame_done !== 1'b1 || bus.out_chain_clear !== 1'b1
            || bus.out_dec_enable !== 1'b0) begin
            errors++;
            $display("FAIL close_timing got done=%b clr=%b dec=%b exp 1 1 0",
                     bus.out_frame_done, bus.out_chain_clear, bus.out_dec_enable);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.in_enable = 1'b0;
        bus.in_sof_detected = 1'b0;
        bus.in_bit_valid = 1'b0;
        bus.in_bit = 1'b0;
        bus.in_eof = 1'b0;
        repeat (3) tick();
        @(negedge clk);
        checks++;
        if ({bus.out_dec_enable, bus.out_chain_clear, bus.out_byte,
             bus.out_byte_valid, bus.out_byte_cnt, bus.out_frame_done,
             bus.out_short_frame, bus.out_parity_err, bus.out_frame_err} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got byte=%02h cnt=%0d dec=%b exp all zero",
                     bus.out_byte, bus.out_byte_cnt, bus.out_dec_enable);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_reqa();
        logic [7:0] d;
        d = 8'h26;
        bus.in_enable = 1'b1;
        tick();
        for (int i = 0; i < 3; i++) send_bit(1'b1);
        bus.in_eof = 1'b1;
        tick();
        bus.in_eof = 1'b0;
        start_frame();
        for (int i = 0; i < 7; i++) send_bit(d[i]);
        exp_bytes.push_back(8'h26);
        exp_frames.push_back('{0, 1'b1, 1'b0, 1'b0});
        send_eof();
        checks++;
        if (bus.out_byte_valid !== 1'b1 || bus.out_byte !== 8'h26) begin
            errors++;
            $display("FAIL reqa_coincide got v=%b byte=%02h exp v=1 byte=26",
                     bus.out_byte_valid, bus.out_byte);
        end
    endtask

    task automatic test_two_bytes();
        start_frame();
        send_char(8'h93, 1'b0, 1'b1);
        send_char(8'h20, 1'b0, 1'b1);
        exp_frames.push_back('{2, 1'b0, 1'b0, 1'b0});
        send_eof();
    endtask

    task automatic test_parity();
        start_frame();
        send_char(8'h93, 1'b0, 1'b1);
        send_char(8'h20, 1'b1, 1'b1);
        exp_frames.push_back('{2, 1'b0, PAR_ON, 1'b0});
        send_eof();
    endtask

    task automatic test_timeout();
        int  k;
        bit  done;
        start_frame();
        exp_frames.push_back('{1, 1'b0, 1'b0, 1'b1});
        send_char(8'h93, 1'b0, 1'b1);
        k = 1;
        done = 1'b0;
        while (!done && k < 400) begin
            @(negedge clk);
            if (bus.out_frame_done === 1'b1) done = 1'b1;
            else k++;
        end
        checks++;
        if (!done || k < 128 || k > 130 || bus.out_dec_enable !== 1'b0) begin
            errors++;
            $display("FAIL timeout got done=%b cycles=%0d dec=%b exp done=1 cycles=128..130 dec=0",
                     done, k, bus.out_dec_enable);
        end
    endtask

    task automatic test_bad_len();
        start_frame();
        send_char(8'h93, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) send_bit(1'b1);
        exp_frames.push_back('{1, 1'b0, 1'b0, 1'b1});
        send_eof();
    endtask

    task automatic test_bit_eof_same();
        logic [7:0] d;
        d = 8'h20;
        start_frame();
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        exp_bytes.push_back(d);
        exp_frames.push_back('{1, 1'b0, 1'b0, 1'b0});
        bus.in_bit_valid = 1'b1;
        bus.in_bit = ~^d;
        bus.in_eof = 1'b1;
        tick();
        bus.in_bit_valid = 1'b0;
        bus.in_bit = 1'b0;
        bus.in_eof = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.out_frame_done !== 1'b1 || bus.out_byte_valid !== 1'b1
            || bus.out_byte_cnt !== 7'd1 || bus.out_frame_err !== 1'b0) begin
            errors++;
            $display("FAIL bit_eof_same got done=%b v=%b cnt=%0d fe=%b exp 1 1 1 0",
                     bus.out_frame_done, bus.out_byte_valid, bus.out_byte_cnt,
                     bus.out_frame_err);
        end
    endtask

    task automatic test_overflow();
        int n0;
        logic [7:0] d;
        start_frame();
        n0 = n_done;
        exp_frames.push_back('{MAXB, 1'b0, 1'b0, 1'b1});
        for (int i = 0; i <= MAXB; i++) begin
            d = 8'($urandom_range(0, 255));
            send_char(d, 1'b0, i < MAXB);
        end
        checks++;
        if (n_done !== n0 + 1 || bus.out_dec_enable !== 1'b0) begin
            errors++;
            $display("FAIL overflow_close got frames=%0d dec=%b exp frames=%0d dec=0",
                     n_done - n0, bus.out_dec_enable, 1);
        end
    endtask

    task automatic test_enable_drop();
        bus.in_enable = 1'b1;
        tick();
        bus.in_enable = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.out_chain_clear !== 1'b1 || bus.out_dec_enable !== 1'b0) begin
            errors++;
            $display("FAIL sof_wait_drop got clr=%b dec=%b exp 1 0",
                     bus.out_chain_clear, bus.out_dec_enable);
        end
        tick();
        @(negedge clk);
        checks++;
        if (bus.out_chain_clear !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_drop got clr=%b exp 0", bus.out_chain_clear);
        end
    endtask

    task automatic test_enable_mid_frame();
        start_frame();
        send_char(8'h55, 1'b0, 1'b1);
        bus.in_enable = 1'b0;
        send_char(8'hAA, 1'b0, 1'b1);
        exp_frames.push_back('{2, 1'b0, 1'b0, 1'b0});
        send_eof();
        tick();
        @(negedge clk);
        checks++;
        if (bus.out_chain_clear !== 1'b0 || bus.out_dec_enable !== 1'b0) begin
            errors++;
            $display("FAIL exit_to_idle got clr=%b dec=%b exp 0 0",
                     bus.out_chain_clear, bus.out_dec_enable);
        end
    endtask

    task automatic test_reset_mid();
        int n0;
        start_frame();
        for (int i = 0; i < 5; i++) send_bit(1'b1);
        n0 = n_done;
        rst = 1'b1;
        tick();
        @(negedge clk);
        checks++;
        if ({bus.out_dec_enable, bus.out_chain_clear, bus.out_byte,
             bus.out_byte_valid, bus.out_byte_cnt, bus.out_frame_done,
             bus.out_short_frame, bus.out_parity_err, bus.out_frame_err} !== '0) begin
            errors++;
            $display("FAIL reset_mid got dec=%b byte=%02h cnt=%0d exp all zero",
                     bus.out_dec_enable, bus.out_byte, bus.out_byte_cnt);
        end
        bus.in_enable = 1'b0;
        tick();
        rst = 1'b0;
        repeat (4) tick();
        checks++;
        if (n_done !== n0 || bus.out_dec_enable !== 1'b0) begin
            errors++;
            $display("FAIL reset_no_done got frames=%0d dec=%b exp frames=0 dec=0",
                     n_done - n0, bus.out_dec_enable);
        end
    endtask

    initial begin
        test_reset();
        test_reqa();
        test_two_bytes();
        test_parity();
        test_timeout();
        test_bad_len();
        test_bit_eof_same();
        test_overflow();
        test_enable_drop();
        test_enable_mid_frame();
        test_reset_mid();
        repeat (3) tick();
        checks++;
        if (exp_bytes.size() != 0 || exp_frames.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got bytes=%0d frames=%0d exp 0 0",
                     exp_bytes.size(), exp_frames.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
